// File: rtl/mm_tiled_pkg.sv
// Shared definitions for the tiled row-times-matrix datapath.
// Contents: default configuration values and derived widths, and
// the requantisation helpers. These are an arithmetic right shift
// and a signed saturation. Both work on a 64-bit signed value, so
// any ACC_WIDTH up to 64 can use them.
package mm_tiled_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH      = 32;
    localparam int DEF_ROW_NUM        = 32;
    localparam int DEF_COL_NUM        = 32;
    localparam int DEF_LENGTH         = 32;
    localparam int DEF_TILE_LEN       = 8;
    localparam int DEF_NUM_TILES      = DEF_LENGTH / DEF_TILE_LEN;
    localparam int DEF_ROW_ADDR_WIDTH = $clog2(DEF_ROW_NUM);
    localparam int DEF_K_ADDR_WIDTH   = $clog2(DEF_LENGTH);
    localparam int DEF_SHIFT_WIDTH    = $clog2(DEF_ACC_WIDTH);

    // A single tile still needs a 1-bit counter so that the port and
    // the register widths stay legal.
    function automatic int tile_cnt_width(input int num_tiles);
        return (num_tiles > 1) ? $clog2(num_tiles) : 1;
    endfunction

    localparam int DEF_TILE_CNT_WIDTH = tile_cnt_width(DEF_NUM_TILES);

    function automatic logic signed [63:0] requant(input logic signed [63:0] v,
                                                   input int              sh);
        return v >>> sh;
    endfunction

    // Clamp to the range of a dw-bit signed value.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input int              dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/mm_tiled_stream_dpath_tile_dot_col.sv
// tile_dot_col: dot product of one column for one input tile.
// The block is purely combinational.
//   a_i   : TILE_LEN signed activations, element 0 in the LSBs
//   w_i   : TILE_LEN signed weights for this column, element 0 in the LSBs
//   dot_o : sum of the products, sign-extended to ACC_WIDTH
module tile_dot_col
    import mm_tiled_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int TILE_LEN   = DEF_TILE_LEN
) (
    input  logic [DATA_WIDTH*TILE_LEN-1:0] a_i,
    input  logic [DATA_WIDTH*TILE_LEN-1:0] w_i,
    output logic signed [ACC_WIDTH-1:0]    dot_o
);

    logic signed [2*DATA_WIDTH-1:0] prod [TILE_LEN];

    // Synthesis balances this chained sum into an adder tree.
    always_comb begin
        dot_o = '0;
        for (int e = 0; e < TILE_LEN; e++) begin
            prod[e] = $signed(a_i[e*DATA_WIDTH +: DATA_WIDTH]) *
                      $signed(w_i[e*DATA_WIDTH +: DATA_WIDTH]);
            dot_o   = dot_o + ACC_WIDTH'(prod[e]);
        end
    end

endmodule

// File: rtl/mm_tiled_stream_dpath.sv
// mm_tiled_stream_dpath: multiplies each streamed row by a resident
// LENGTH x COL_NUM signed weight matrix.
// Ports:
//   clk, reset (async, active low)
//   wt_wr_*      : write one weight row (all columns at index k);
//                  writes are accepted only while the block is idle
//   in_*         : one beat carries TILE_LEN elements; in_row_addr and
//                  cfg_shift are taken from the last beat of a row
//   out_*        : one saturated result row per source row
//   busy         : a row is in progress or the pipeline is occupied
// Handshake: a beat transfers on a clock edge where in_valid && in_ready.
// A result transfers where out_valid && out_ready. While
// out_valid && !out_ready the whole pipeline stalls. In that state
// in_ready is low, S1 holds, and out_data/out_row_addr are frozen.
module mm_tiled_stream_dpath
    import mm_tiled_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int ROW_NUM    = DEF_ROW_NUM,
    parameter int COL_NUM    = DEF_COL_NUM,
    parameter int LENGTH     = DEF_LENGTH,
    parameter int TILE_LEN   = DEF_TILE_LEN,
    localparam int NUM_TILES      = LENGTH / TILE_LEN,
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM),
    localparam int K_ADDR_WIDTH   = $clog2(LENGTH),
    localparam int TILE_CNT_WIDTH = tile_cnt_width(NUM_TILES),
    localparam int SHIFT_WIDTH    = $clog2(ACC_WIDTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wt_wr_en,
    input  logic [K_ADDR_WIDTH-1:0]        wt_wr_k,
    input  logic [DATA_WIDTH*COL_NUM-1:0]  wt_wr_data,
    output logic                           wt_wr_ready,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH*TILE_LEN-1:0] in_data,
    input  logic [ROW_ADDR_WIDTH-1:0]      in_row_addr,
    input  logic [SHIFT_WIDTH-1:0]         cfg_shift,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH*COL_NUM-1:0]  out_data,
    output logic [ROW_ADDR_WIDTH-1:0]      out_row_addr,
    output logic                           busy
);

    logic signed [DATA_WIDTH-1:0] w_q [LENGTH][COL_NUM];
    logic [TILE_CNT_WIDTH-1:0]    tcnt_q;

    logic                         s1_valid_q;
    logic                         s1_first_q;
    logic                         s1_last_q;
    logic [ROW_ADDR_WIDTH-1:0]    s1_addr_q;
    logic [SHIFT_WIDTH-1:0]       s1_shift_q;
    logic signed [ACC_WIDTH-1:0]  s1_dot_q [COL_NUM];

    logic signed [ACC_WIDTH-1:0]  acc_q [COL_NUM];
    logic                         out_valid_q;
    logic [DATA_WIDTH*COL_NUM-1:0] out_data_q;
    logic [ROW_ADDR_WIDTH-1:0]    out_addr_q;

    logic                         adv;
    logic                         accept;
    logic                         first_w;
    logic                         last_w;
    logic [K_ADDR_WIDTH-1:0]      kidx;
    logic [DATA_WIDTH*TILE_LEN-1:0] tile_w [COL_NUM];
    logic signed [ACC_WIDTH-1:0]  dot_w [COL_NUM];
    logic signed [ACC_WIDTH-1:0]  sum_w [COL_NUM];
    logic signed [63:0]           sat_w [COL_NUM];
    logic [DATA_WIDTH*COL_NUM-1:0] res_w;

    assign adv         = !(out_valid_q && !out_ready);
    assign accept      = in_valid && adv;
    assign in_ready    = adv;
    assign busy        = (tcnt_q != '0) || s1_valid_q || out_valid_q;
    assign wt_wr_ready = !busy;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_row_addr = out_addr_q;

    assign first_w = (tcnt_q == '0);
    assign last_w  = (tcnt_q == TILE_CNT_WIDTH'(NUM_TILES - 1));

    // Select the weights for the current tile. The weights of tile t
    // are at rows t*TILE_LEN .. t*TILE_LEN+TILE_LEN-1.
    always_comb begin
        kidx = '0;
        for (int j = 0; j < COL_NUM; j++) begin
            tile_w[j] = '0;
            for (int e = 0; e < TILE_LEN; e++) begin
                kidx = K_ADDR_WIDTH'(int'(tcnt_q) * TILE_LEN + e);
                tile_w[j][e*DATA_WIDTH +: DATA_WIDTH] = w_q[kidx][j];
            end
        end
    end

    for (genvar j = 0; j < COL_NUM; j++) begin : g_col
        tile_dot_col #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .TILE_LEN   (TILE_LEN)
        ) u_col (
            .a_i   (in_data),
            .w_i   (tile_w[j]),
            .dot_o (dot_w[j])
        );
    end

    // S2 combinational part: accumulate, then requantise the finished sum.
    // The accumulator wraps at ACC_WIDTH bits.
    always_comb begin
        res_w = '0;
        for (int j = 0; j < COL_NUM; j++) begin
            sum_w[j] = s1_first_q ? s1_dot_q[j] : acc_q[j] + s1_dot_q[j];
            sat_w[j] = sat(requant(64'(sum_w[j]), int'(s1_shift_q)), DATA_WIDTH);
            res_w[j*DATA_WIDTH +: DATA_WIDTH] = sat_w[j][DATA_WIDTH-1:0];
        end
    end

    // A write is dropped while busy. A beat that is accepted on the same
    // edge as a write still reads the old weights.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LENGTH; k++)
                for (int j = 0; j < COL_NUM; j++)
                    w_q[k][j] <= '0;
        end else if (wt_wr_en && !busy) begin
            for (int j = 0; j < COL_NUM; j++)
                w_q[wt_wr_k][j] <= wt_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_addr_q   <= '0;
            s1_shift_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            for (int j = 0; j < COL_NUM; j++) begin
                s1_dot_q[j] <= '0;
                acc_q[j]    <= '0;
            end
        end else begin
            if (accept)
                tcnt_q <= last_w ? '0 : tcnt_q + 1'b1;

            if (adv) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_dot_q   <= dot_w;
                    s1_first_q <= first_w;
                    s1_last_q  <= last_w;
                    s1_addr_q  <= in_row_addr;
                    s1_shift_q <= cfg_shift;
                end
                if (s1_valid_q) begin
                    if (s1_last_q) begin
                        out_data_q <= res_w;
                        out_addr_q <= s1_addr_q;
                    end else begin
                        acc_q <= sum_w;
                    end
                end
            end

            // Loading a new result takes priority over the handshake clear.
            if (adv && s1_valid_q && s1_last_q)
                out_valid_q <= 1'b1;
            else if (out_ready)
                out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mm_tiled_stream_dpath.sv
// Bench for mm_tiled_stream_dpath. Configuration: DW=8, COL_NUM=4,
// LENGTH=32, TILE_LEN=8, so each row is 4 beats.
// Expected result rows are hand-computed constants. Each one is packed
// as {addr, col3, col2, col1, col0} and queued before its row is sent.
module tb_mm_tiled_stream_dpath;

    logic        clk;
    logic        reset;
    logic        wt_wr_en;
    logic [4:0]  wt_wr_k;
    logic [31:0] wt_wr_data;
    logic        wt_wr_ready;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [4:0]  in_row_addr;
    logic [4:0]  cfg_shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_row_addr;
    logic        busy;

    mm_tiled_stream_dpath #(
        .DATA_WIDTH (8),
        .ACC_WIDTH  (32),
        .ROW_NUM    (32),
        .COL_NUM    (4),
        .LENGTH     (32),
        .TILE_LEN   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wt_wr_en     (wt_wr_en),
        .wt_wr_k      (wt_wr_k),
        .wt_wr_data   (wt_wr_data),
        .wt_wr_ready  (wt_wr_ready),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_row_addr  (in_row_addr),
        .cfg_shift    (cfg_shift),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row_addr (out_row_addr),
        .busy         (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [36:0] exp_q[$];
    int          hs_cyc[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          last_acc_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    // The monitor runs on the falling edge. A result seen here with
    // out_valid && out_ready transfers on the next rising edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL row_out: got unexpected row addr %0d data %h", out_row_addr, out_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("row_out", 64'({out_row_addr, out_data}), 64'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_wt(input logic [4:0] k, input logic [31:0] d);
        wt_wr_en   = 1'b1;
        wt_wr_k    = k;
        wt_wr_data = d;
        @(posedge clk); #1;
        wt_wr_en   = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) check("idle_timeout", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic load_cols(input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3);
        wait_idle();
        for (int k = 0; k < 32; k++) write_wt(5'(k), {c3, c2, c1, c0});
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [4:0] addr, input logic [4:0] sh);
        bit ok;
        in_valid    = 1'b1;
        in_data     = d;
        in_row_addr = addr;
        cfg_shift   = sh;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; last_acc_cyc = cyc; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) check("beat_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic send_row(input logic [7:0] fill, input logic [4:0] addr, input logic [4:0] sh,
                            input bit wr_first, input logic [31:0] wr_data);
        for (int t = 0; t < 4; t++) begin
            if (wr_first && t == 0) begin
                wt_wr_en   = 1'b1;
                wt_wr_k    = 5'd0;
                wt_wr_data = wr_data;
            end
            send_beat({8{fill}}, addr, sh);
            wt_wr_en = 1'b0;
        end
    endtask

    task automatic check_reset_outs(input string name);
        check(name, 64'({out_valid, busy, in_ready, wt_wr_ready, out_row_addr, out_data}),
              64'({1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0}));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t3_acc;
        bit ok;
        reset = 1'b0; wt_wr_en = 1'b0; wt_wr_k = '0; wt_wr_data = '0;
        in_valid = 1'b0; in_data = '0; in_row_addr = '0; cfg_shift = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("in_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_outs("after_reset");
        @(posedge clk); #1;

        // 1: column 0 weights 1. Row of 2s gives 64 (shift 0) and 32 (shift 1).
        //    A row of 5s gives 160, which saturates to 127.
        load_cols(8'h01, 8'h00, 8'h00, 8'h00);
        push_exp(5'd1, 32'h00000040); send_row(8'h02, 5'd1, 5'd0, 0, '0);
        push_exp(5'd2, 32'h00000020); send_row(8'h02, 5'd2, 5'd1, 0, '0);
        push_exp(5'd3, 32'h0000007F); send_row(8'h05, 5'd3, 5'd0, 0, '0);
        wait_drain();

        // 2: weights are col0=-1 and col2=127; the row is all -128.
        //    col0 = 4096 and col2 = -520192.
        //    With shift 0 these saturate to 0x7F and 0x80.
        //    With shift 12 they become 1 and -127.
        load_cols(8'hFF, 8'h00, 8'h7F, 8'h00);
        push_exp(5'd20, 32'h0080007F); send_row(8'h80, 5'd20, 5'd0, 0, '0);
        push_exp(5'd21, 32'h00810001); send_row(8'h80, 5'd21, 5'd12, 0, '0);
        wait_drain();

        // 3: weights col0=1, col1=2, col2=-1. Three rows are sent back to back.
        load_cols(8'h01, 8'h02, 8'hFF, 8'h00);
        hs_cyc.delete();
        push_exp(5'd5, 32'h00E04020);
        push_exp(5'd6, 32'h00A07F60);
        push_exp(5'd7, 32'h004080C0);
        send_row(8'h01, 5'd5, 5'd0, 0, '0);
        t3_acc = last_acc_cyc;
        send_row(8'h03, 5'd6, 5'd0, 0, '0);
        send_row(8'hFE, 5'd7, 5'd0, 0, '0);
        wait_drain();
        check("t3_pulses", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() >= 3) begin
            check("t3_latency", 64'(hs_cyc[0] - t3_acc), 64'd2);
            check("t3_spacing1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd4);
            check("t3_spacing2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd4);
        end

        // 4: backpressure. The result must hold for 10 cycles with in_ready low.
        wait_idle();
        out_ready = 1'b0;
        push_exp(5'd9, 32'h00E04020);
        send_row(8'h01, 5'd9, 5'd0, 0, '0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        check("t4_valid_seen", 64'(ok), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("t4_stall_hold", 64'({in_ready, out_valid, out_row_addr, out_data}),
                  64'({1'b0, 1'b1, 5'd9, 32'h00E04020}));
            if (i < 9) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_after_hs", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
        check("t4_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // 5: reset in the middle of a row. The weights are cleared too.
        send_beat({8{8'h07}}, 5'd11, 5'd0);
        send_beat({8{8'h07}}, 5'd11, 5'd0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outs("t5_mid_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        push_exp(5'd4, 32'h00000000); send_row(8'h01, 5'd4, 5'd0, 0, '0);
        load_cols(8'h01, 8'h00, 8'h00, 8'h00);
        push_exp(5'd3, 32'h00000020); send_row(8'h01, 5'd3, 5'd0, 0, '0);
        wait_drain();

        // 6: writes while busy must be dropped. k=30,31 are in the last tile.
        wait_idle();
        push_exp(5'd12, 32'h00000020);
        send_beat({8{8'h01}}, 5'd12, 5'd0);
        send_beat({8{8'h01}}, 5'd12, 5'd0);
        @(negedge clk);
        check("t6_busy_wr_ready", 64'({busy, wt_wr_ready}), 64'({1'b1, 1'b0}));
        @(posedge clk); #1;
        write_wt(5'd31, 32'h05050505);
        write_wt(5'd30, 32'h05050505);
        send_beat({8{8'h01}}, 5'd12, 5'd0);
        send_beat({8{8'h01}}, 5'd12, 5'd0);
        push_exp(5'd13, 32'h00000020); send_row(8'h01, 5'd13, 5'd0, 0, '0);
        wait_drain();
        // An idle write to k=31 is accepted.
        wait_idle();
        write_wt(5'd31, 32'h05050505);
        // A write to k=0 in the same cycle as the first beat: that beat
        // still uses the old k=0 weights, and the next row sees the new ones.
        push_exp(5'd14, 32'h05050524); send_row(8'h01, 5'd14, 5'd0, 1, 32'h03030303);
        push_exp(5'd15, 32'h08080826); send_row(8'h01, 5'd15, 5'd0, 0, '0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
